// File: rtl/test_result_monitor_pkg.sv
// Shared types, default addresses and the checksum step for the test result monitor.
package test_mon_pkg;

   localparam logic [15:0] RESULT_ADDR = 16'h0030;
   localparam logic [7:0]  EXPECTED    = 8'h9D;
   localparam logic [15:0] DONE_ADDR   = 16'h00FF;
   localparam logic [15:0] WIN_BASE    = 16'h0030;
   localparam logic [15:0] WIN_LAST    = 16'h003F;
   localparam int unsigned TIMEOUT     = 240;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StDone,
      StTimeout
   } mon_state_t;

   // Rotate left by one, then fold in the new byte.
   function automatic logic [7:0] sig_step(input logic [7:0] cur, input logic [7:0] data);
      return {cur[6:0], cur[7]} ^ data;
   endfunction

endpackage

// File: rtl/test_result_monitor_if.sv
// CPU memory bus as seen by passive observers.
interface test_result_monitor_if;

   logic [15:0] address;
   logic [7:0]  data_out;
   logic        mem_write;

   modport master (output address, output data_out, output mem_write);
   modport slave  (input address, input data_out, input mem_write);

endinterface

// File: rtl/test_result_monitor_timeout_counter.sv
// Cycle counter for the armed phase; flags the last permitted cycle.
module timeout_counter #(
   parameter int unsigned Timeout = 240
) (
   input  logic ph2,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned Width = $clog2(Timeout + 1);

   logic [Width-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != Width'(Timeout))) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == Width'(Timeout - 1));

endmodule

// File: rtl/test_result_monitor.sv
// Passive bus observer: captures the test result and window signature, then reports
// pass/fail on the done-marker write or timeout if the marker never arrives.
module test_result_monitor
   import test_mon_pkg::*;
#(
   parameter logic [15:0] ResultAddr = RESULT_ADDR,
   parameter logic [7:0]  Expected   = EXPECTED,
   parameter logic [15:0] DoneAddr   = DONE_ADDR,
   parameter logic [15:0] WinBase    = WIN_BASE,
   parameter logic [15:0] WinLast    = WIN_LAST,
   parameter int unsigned Timeout    = TIMEOUT
) (
   input  logic                        ph2,
   input  logic                        reset,
   input  logic                        start,
   test_result_monitor_if.slave        bus,
   output logic                        armed,
   output logic                        done,
   output logic                        pass,
   output logic                        timed_out,
   output logic [7:0]                  result,
   output logic [7:0]                  write_count,
   output logic [7:0]                  checksum
);

   mon_state_t state_d, state_q;
   logic       done_d, done_q;
   logic       pass_d, pass_q;
   logic       timed_out_d, timed_out_q;
   logic       result_seen_d, result_seen_q;
   logic [7:0] result_d, result_q;
   logic [7:0] write_count_d, write_count_q;
   logic [7:0] checksum_d, checksum_q;
   logic       ctr_enable, expired;

   assign ctr_enable = (state_q == StArmed) && !start;

   timeout_counter #(
      .Timeout (Timeout)
   ) u_timeout_counter (
      .ph2     (ph2),
      .reset   (reset),
      .clear   (start),
      .enable  (ctr_enable),
      .expired (expired)
   );

   always_comb begin
      state_d       = state_q;
      done_d        = done_q;
      pass_d        = pass_q;
      timed_out_d   = timed_out_q;
      result_seen_d = result_seen_q;
      result_d      = result_q;
      write_count_d = write_count_q;
      checksum_d    = checksum_q;
      if (start) begin
         state_d       = StArmed;
         done_d        = 1'b0;
         pass_d        = 1'b0;
         timed_out_d   = 1'b0;
         result_seen_d = 1'b0;
         result_d      = '0;
         write_count_d = '0;
         checksum_d    = '0;
      end else if (state_q == StArmed) begin
         if (bus.mem_write) begin
            if (write_count_q != 8'hFF) begin
               write_count_d = write_count_q + 8'd1;
            end
            if (bus.address == ResultAddr) begin
               result_d      = bus.data_out;
               result_seen_d = 1'b1;
            end
            if ((bus.address >= WinBase) && (bus.address <= WinLast)) begin
               checksum_d = sig_step(checksum_q, bus.data_out);
            end
            // Verdict uses the primed capture so a same-cycle result write counts.
            if (bus.address == DoneAddr) begin
               state_d     = StDone;
               done_d      = 1'b1;
               timed_out_d = 1'b0;
               pass_d      = result_seen_d && (result_d == Expected);
            end
         end
         if ((state_d != StDone) && expired) begin
            state_d     = StTimeout;
            done_d      = 1'b1;
            timed_out_d = 1'b1;
            pass_d      = 1'b0;
         end
      end
   end

   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         timed_out_q   <= 1'b0;
         result_seen_q <= 1'b0;
         result_q      <= '0;
         write_count_q <= '0;
         checksum_q    <= '0;
      end else begin
         state_q       <= state_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         timed_out_q   <= timed_out_d;
         result_seen_q <= result_seen_d;
         result_q      <= result_d;
         write_count_q <= write_count_d;
         checksum_q    <= checksum_d;
      end
   end

   assign armed       = (state_q == StArmed);
   assign done        = done_q;
   assign pass        = pass_q;
   assign timed_out   = timed_out_q;
   assign result      = result_q;
   assign write_count = write_count_q;
   assign checksum    = checksum_q;

endmodule
